// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM and its AXI slave front-end.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ram_pkg;

   // Result a port returns when it reads and writes the same word in one cycle.
   typedef enum logic [1:0] {
      WRITE_FIRST,
      READ_FIRST,
      NO_CHANGE
   } rw_mode_e;

   localparam int MAX_READ_LATENCY = 4;

   // Widest word merge_bytes can handle; callers zero-extend into it and
   // truncate the result back to their own word width.
   localparam int MAX_DATA_W = 1024;
   localparam int LANE_W     = $clog2(MAX_DATA_W);

   // Replace the byte lanes of old_w whose enable is set with the matching
   // lanes of new_w. Lane width is a runtime argument so one function serves
   // every word geometry.
   function automatic logic [MAX_DATA_W-1:0] merge_bytes(
      input logic [MAX_DATA_W-1:0] old_w,
      input logic [MAX_DATA_W-1:0] new_w,
      input logic [MAX_DATA_W-1:0] byte_en,
      input int unsigned           byte_w
   );
      logic [MAX_DATA_W-1:0] res;
      logic [LANE_W-1:0]     lane;
      res = old_w;
      for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
         lane = LANE_W'(b / byte_w);
         if (byte_en[lane]) begin
            res[b] = new_w[b];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// Read-return pipe for one RAM port: delays data and valid by LAT cycles.
// Latency: LAT cycles from in_vld_i sample to out_vld_o; one word per cycle.
// Backpressure: none, every input is accepted; out_dat_o holds when idle.
//
// Ports: clk_i, rst_n (async, active low); in_vld_i/in_dat_i enter at the
// acceptance edge; out_vld_o/out_dat_o are the last stage.
module ram_port_pipe #(
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              in_vld_i,
   input  logic [DATA_W-1:0] in_dat_i,
   output logic              out_vld_o,
   output logic [DATA_W-1:0] out_dat_o
);

   logic [LAT-1:0]    vld_q;
   logic [DATA_W-1:0] dat_q [LAT];

   // Data stages load only behind a valid bit, so the last stage keeps the
   // most recently returned word between pulses.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_vld_i;
         if (in_vld_i) begin
            dat_q[0] <= in_dat_i;
         end
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign out_vld_o = vld_q[LAT-1];
   assign out_dat_o = dat_q[LAT-1];

endmodule

// File: rtl/ram_dp_pipe.sv
// True dual-port byte-enabled RAM with pipelined read return and write-write arbitration.
// Latency: READ_LATENCY cycles from accepted req to rdata/rvalid on each port.
// Backpressure: none; a req is accepted in the cycle it is asserted.
//
// Ports: clk_i, rst_n (async, active low); per port x in {a,b}: req_x, we_x,
// addr_x, wdata_x, byte_en_x in; rdata_x, rvalid_x out. collision_cnt_o counts
// same-address write-write cycles, saturating.
module ram_dp_pipe
   import ram_pkg::*;
#(
   parameter int       ADDR_WIDTH   = 16,
   parameter int       BATCH_WIDTH  = 4,
   parameter int       BYTE_WIDTH   = 8,
   parameter int       READ_LATENCY = 1,
   parameter rw_mode_e RW_MODE_A    = WRITE_FIRST,
   parameter rw_mode_e RW_MODE_B    = WRITE_FIRST,
   parameter bit       PRIORITY_A   = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_n,
   input  logic                              req_a,
   input  logic                              we_a,
   input  logic [ADDR_WIDTH-1:0]             addr_a,
   input  logic [BATCH_WIDTH*BYTE_WIDTH-1:0] wdata_a,
   input  logic [BATCH_WIDTH-1:0]            byte_en_a,
   output logic [BATCH_WIDTH*BYTE_WIDTH-1:0] rdata_a,
   output logic                              rvalid_a,
   input  logic                              req_b,
   input  logic                              we_b,
   input  logic [ADDR_WIDTH-1:0]             addr_b,
   input  logic [BATCH_WIDTH*BYTE_WIDTH-1:0] wdata_b,
   input  logic [BATCH_WIDTH-1:0]            byte_en_b,
   output logic [BATCH_WIDTH*BYTE_WIDTH-1:0] rdata_b,
   output logic                              rvalid_b,
   output logic [15:0]                       collision_cnt_o
);

   localparam int DW    = BATCH_WIDTH * BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY || BATCH_WIDTH < 1 ||
       BYTE_WIDTH < 1 || DW > MAX_DATA_W) begin : g_param_err
      $fatal(1, "ram_dp_pipe: READ_LATENCY must be 1..4, BATCH_WIDTH and BYTE_WIDTH >= 1");
   end

   function automatic logic [DW-1:0] merge_word(
      input logic [DW-1:0]          old_w,
      input logic [DW-1:0]          new_w,
      input logic [BATCH_WIDTH-1:0] be
   );
      return DW'(merge_bytes(MAX_DATA_W'(old_w), MAX_DATA_W'(new_w),
                             MAX_DATA_W'(be), BYTE_WIDTH));
   endfunction

   logic [DW-1:0] mem_q [DEPTH];

   logic          wr_a, wr_b, coll;
   logic [DW-1:0] old_a, old_b, mrg_a, mrg_b, coll_word, fin_a, fin_b;
   logic          pipe_vld_a, pipe_vld_b;
   logic [DW-1:0] pipe_dat_a, pipe_dat_b;
   logic [15:0]   cnt_q, cnt_d;

   assign wr_a  = req_a & we_a;
   assign wr_b  = req_b & we_b;
   assign coll  = wr_a & wr_b & (addr_a == addr_b);

   // Pre-write contents; this is what a plain read samples at the edge.
   assign old_a = mem_q[addr_a];
   assign old_b = mem_q[addr_b];

   assign mrg_a = merge_word(old_a, wdata_a, byte_en_a);
   assign mrg_b = merge_word(old_b, wdata_b, byte_en_b);

   // On a collision the losing port is applied first and the winner merged
   // over it, so bytes enabled on both sides come from the priority port and
   // bytes enabled on one side only come from that side.
   assign coll_word = PRIORITY_A ? merge_word(mrg_b, wdata_a, byte_en_a)
                                 : merge_word(mrg_a, wdata_b, byte_en_b);

   assign fin_a = coll ? coll_word : mrg_a;
   assign fin_b = coll ? coll_word : mrg_b;

   // Both ports' writes live in one process; on a collision both carry the
   // same word and port B's redundant write is dropped.
   always_ff @(posedge clk_i) begin
      if (wr_a) begin
         mem_q[addr_a] <= fin_a;
      end
      if (wr_b && !coll) begin
         mem_q[addr_b] <= fin_b;
      end
   end

   always_comb begin
      pipe_vld_a = req_a;
      pipe_dat_a = old_a;
      if (wr_a) begin
         case (RW_MODE_A)
            WRITE_FIRST: pipe_dat_a = fin_a;
            READ_FIRST:  pipe_dat_a = old_a;
            NO_CHANGE:   pipe_vld_a = 1'b0;
            default:     pipe_vld_a = 1'b0;
         endcase
      end
   end

   always_comb begin
      pipe_vld_b = req_b;
      pipe_dat_b = old_b;
      if (wr_b) begin
         case (RW_MODE_B)
            WRITE_FIRST: pipe_dat_b = fin_b;
            READ_FIRST:  pipe_dat_b = old_b;
            NO_CHANGE:   pipe_vld_b = 1'b0;
            default:     pipe_vld_b = 1'b0;
         endcase
      end
   end

   ram_port_pipe #(.DATA_W(DW), .LAT(READ_LATENCY)) u_pipe_a (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .in_vld_i  (pipe_vld_a),
      .in_dat_i  (pipe_dat_a),
      .out_vld_o (rvalid_a),
      .out_dat_o (rdata_a)
   );

   ram_port_pipe #(.DATA_W(DW), .LAT(READ_LATENCY)) u_pipe_b (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .in_vld_i  (pipe_vld_b),
      .in_dat_i  (pipe_dat_b),
      .out_vld_o (rvalid_b),
      .out_dat_o (rdata_b)
   );

   assign cnt_d = (coll && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign collision_cnt_o = cnt_q;

endmodule
